// File: rtl/dm_access_pkg.sv
// Shared encodings, FSM state codes, latched request layout and lane helpers
// for the data-memory access controller.
package dm_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD     = 3'd1;
    localparam state_t ST_RMW_RD = 3'd2;
    localparam state_t ST_WR     = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sign;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

    // Byte-enable of the lanes touched by an access; size 2'b11 behaves as word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'(4'b0001 << off);
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Pipeline request/response and data-memory bus of the access controller.
// The controller connects through the slave modport; the environment uses master.
interface dm_access_ctrl_if;
    import dm_access_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              misalign_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output stall, rsp_valid, rsp_rdata, misalign_err,
        output mem_address, mem_write_data, mem_memread, mem_memwrite
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  stall, rsp_valid, rsp_rdata, misalign_err,
        input  mem_address, mem_write_data, mem_memread, mem_memwrite
    );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational little-endian lane handling: load extract + sign/zero extend,
// and store merge of byte/half data into the word read back from memory.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_c,
    output logic [DATA_W-1:0] merge_c
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] wrep;
    logic [3:0]        be;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        load_c  = shifted;
        wrep    = wdata;
        case (size)
            SZ_BYTE: begin
                load_c = {{24{sign & shifted[7]}}, shifted[7:0]};
                wrep   = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_c = {{16{sign & shifted[15]}}, shifted[15:0]};
                wrep   = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        // Replicated store data lands only in the enabled lanes.
        be      = lane_mask(size, off);
        merge_c = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merge_c[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Memory-stage initiator for the word-wide data memory: loads, word stores and
// read-modify-write byte/half stores. Define DM_ACCESS_STATS_EN for counters.
module dm_access_ctrl
    import dm_access_pkg::*;
`ifdef DM_ACCESS_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    dm_access_ctrl_if.slave bus
`ifdef DM_ACCESS_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_loads,
    output logic [CNT_W-1:0] stat_stores,
    output logic [CNT_W-1:0] stat_misalign
`endif
);

    state_t            state_q, state_d;
    dm_req_t           req_q, req_d;
    logic              mem_memread_q, mem_memread_d;
    logic              mem_memwrite_q, mem_memwrite_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              misalign_err_q, misalign_err_d;
    logic [DATA_W-1:0] load_c, merge_c;

    dm_lane_align u_align (
        .off     (req_q.addr[1:0]),
        .size    (req_q.size),
        .sign    (req_q.sign),
        .rdata   (bus.mem_read_data),
        .wdata   (req_q.wdata),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        mem_write_data_d = '0;
        rsp_rdata_d      = '0;
        misalign_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.addr  = bus.req_addr;
                    req_d.size  = bus.req_size;
                    req_d.sign  = bus.req_signed;
                    req_d.wdata = bus.req_wdata;
                    if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d        = ST_DONE;
                        misalign_err_d = 1'b1;
                    end else if (!bus.req_write) begin
                        state_d = ST_RD;
                    end else if (bus.req_size[1]) begin
                        state_d          = ST_WR;
                        mem_write_data_d = bus.req_wdata;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                state_d     = ST_DONE;
                rsp_rdata_d = load_c;
            end
            ST_RMW_RD: begin
                state_d          = ST_WR;
                mem_write_data_d = merge_c;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Memory strobes and response flags are decodes of the next state.
        rsp_valid_d    = (state_d == ST_DONE);
        mem_memread_d  = (state_d == ST_RD) || (state_d == ST_RMW_RD);
        mem_memwrite_d = (state_d == ST_WR);
        mem_address_d  = (mem_memread_d || mem_memwrite_d) ? {req_d.addr[ADDR_W-1:2], 2'b00} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            misalign_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            mem_memread_q    <= mem_memread_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            misalign_err_q   <= misalign_err_d;
        end
    end

    // Pipeline is held while busy, and in the accept cycle itself.
    assign bus.stall = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                       ((state_q == ST_IDLE) && bus.req_valid);

    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.misalign_err   = misalign_err_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_memread    = mem_memread_q;
    assign bus.mem_memwrite   = mem_memwrite_q;

`ifdef DM_ACCESS_STATS_EN
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] loads_q, loads_d, stores_q, stores_d, mis_q, mis_d;

    always_comb begin
        is_store_d = is_store_q;
        loads_d    = loads_q;
        stores_d   = stores_q;
        mis_d      = mis_q;
        if ((state_q == ST_IDLE) && bus.req_valid) is_store_d = bus.req_write;
        // Counters saturate at all-ones.
        if (rsp_valid_q) begin
            if (misalign_err_q) begin
                if (mis_q != '1) mis_d = mis_q + CNT_W'(1);
            end else if (is_store_q) begin
                if (stores_q != '1) stores_d = stores_q + CNT_W'(1);
            end else begin
                if (loads_q != '1) loads_d = loads_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            loads_q    <= '0;
            stores_q   <= '0;
            mis_q      <= '0;
        end else begin
            is_store_q <= is_store_d;
            loads_q    <= loads_d;
            stores_q   <= stores_d;
            mis_q      <= mis_d;
        end
    end

    assign stat_loads    = loads_q;
    assign stat_stores   = stores_q;
    assign stat_misalign = mis_q;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: vector table plus response scoreboard,
// behavioural data memory, and hand-written reset / back-to-back sequences.
module tb_dm_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dm_access_ctrl_if bus();

`ifdef DM_ACCESS_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_misalign;
    dm_access_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_misalign(stat_misalign)
    );
`else
    dm_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int st_cnt = 0;

    typedef struct {
        string       nm;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       nm;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dm0;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] dm1;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;
    vec_t vt[15];

    // Data memory: reads sampled on negedge, writes and bench preloads on posedge.
    logic [31:0] dm [0:63];
    logic        pre_we = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_val = '0;

    always @(negedge clk)
        if (bus.mem_memread) bus.mem_read_data <= dm[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (pre_we) dm[pre_idx] <= pre_val;
        else if (bus.mem_memwrite) dm[bus.mem_address[7:2]] <= bus.mem_write_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitor: strobe counters, overlap guard and scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_memread)  rd_cnt <= rd_cnt + 1;
        if (bus.mem_memwrite) wr_cnt <= wr_cnt + 1;
        if (bus.stall)        st_cnt <= st_cnt + 1;
        if (bus.mem_memread && bus.mem_memwrite) begin
            n_bad++;
            $display("FAIL rw_overlap: memread and memwrite both 1 at t=%0t", $time);
        end
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_rsp: rsp_valid with nothing expected at t=%0t", $time);
            end else begin
                e = sb.pop_front();
                chk({e.nm, " rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.nm, " err"}, 32'(bus.misalign_err), 32'(e.err));
                chk({e.nm, " rsp_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic dm_load(input int idx, input logic [31:0] v);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = idx; pre_val = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic wait_drain(input string nm);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: %0d responses outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int rd0, wr0, st0;
        exp_t e;
        dm_load(int'(v.addr[7:2]), v.dm0);
        @(posedge clk); #1;
        rd0 = rd_cnt; wr0 = wr_cnt; st0 = st_cnt;
        drive(v.wr, v.sz, v.sg, v.addr, v.wdata);
        e.nm = v.nm; e.cyc = cyc + v.lat; e.rdata = v.rdata; e.err = v.err;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_drain(v.nm);
        @(posedge clk); #1;
        chk({v.nm, " memreads"},  32'(rd_cnt - rd0), 32'(v.nrd));
        chk({v.nm, " memwrites"}, 32'(wr_cnt - wr0), 32'(v.nwr));
        chk({v.nm, " stall_cycles"}, 32'(st_cnt - st0), 32'(v.lat));
        chk({v.nm, " dm_word"}, dm[v.addr[7:2]], v.dm1);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        //        name        wr  sz     sg  addr   wdata         dm0           rdata         err  dm1           lat rd wr
        vt[0]  = '{"lw",      0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2, 1, 0};
        vt[1]  = '{"lb_s",    0, 2'b00, 1, 32'h13, 32'h0,        32'h80112233, 32'hFFFFFF80, 0, 32'h80112233, 2, 1, 0};
        vt[2]  = '{"lbu",     0, 2'b00, 0, 32'h13, 32'h0,        32'h80112233, 32'h00000080, 0, 32'h80112233, 2, 1, 0};
        vt[3]  = '{"sh",      1, 2'b01, 0, 32'h12, 32'h0000ABCD, 32'h11223344, 32'h0,        0, 32'hABCD3344, 3, 1, 1};
        vt[4]  = '{"lw_mis",  0, 2'b10, 0, 32'h21, 32'h0,        32'h55555555, 32'h0,        1, 32'h55555555, 1, 0, 0};
        vt[5]  = '{"sw",      1, 2'b10, 0, 32'h24, 32'hCAFEF00D, 32'h00000000, 32'h0,        0, 32'hCAFEF00D, 2, 0, 1};
        vt[6]  = '{"lh_s",    0, 2'b01, 1, 32'h0A, 32'h0,        32'h80017FFE, 32'hFFFF8001, 0, 32'h80017FFE, 2, 1, 0};
        vt[7]  = '{"lhu",     0, 2'b01, 0, 32'h08, 32'h0,        32'h8001F234, 32'h0000F234, 0, 32'h8001F234, 2, 1, 0};
        vt[8]  = '{"sb_l1",   1, 2'b00, 0, 32'h31, 32'h1234565A, 32'hFFFFFFFF, 32'h0,        0, 32'hFFFF5AFF, 3, 1, 1};
        vt[9]  = '{"sh_mis",  1, 2'b01, 0, 32'h15, 32'h0000BEEF, 32'h01020304, 32'h0,        1, 32'h01020304, 1, 0, 0};
        vt[10] = '{"lb_pos",  0, 2'b00, 1, 32'h40, 32'h0,        32'h0000007F, 32'h0000007F, 0, 32'h0000007F, 2, 1, 0};
        vt[11] = '{"lw_sz3",  0, 2'b11, 0, 32'h44, 32'h0,        32'h01234567, 32'h01234567, 0, 32'h01234567, 2, 1, 0};
        vt[12] = '{"lw_sgn",  0, 2'b10, 1, 32'h48, 32'h0,        32'h80000000, 32'h80000000, 0, 32'h80000000, 2, 1, 0};
        vt[13] = '{"sz3_mis", 0, 2'b11, 0, 32'h4A, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1, 0, 0};
        vt[14] = '{"sh_hi",   1, 2'b01, 0, 32'h52, 32'h00007788, 32'hAABBCCDD, 32'h0,        0, 32'h7788CCDD, 3, 1, 1};

        // Reset state
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst stall",        32'(bus.stall), 32'h0);
        chk("rst rsp_valid",    32'(bus.rsp_valid), 32'h0);
        chk("rst rsp_rdata",    bus.rsp_rdata, 32'h0);
        chk("rst misalign_err", 32'(bus.misalign_err), 32'h0);
        chk("rst mem_address",  bus.mem_address, 32'h0);
        chk("rst mem_wdata",    bus.mem_write_data, 32'h0);
        chk("rst mem_rd_wr",    32'({bus.mem_memread, bus.mem_memwrite}), 32'h0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vt[i]);

        // Reset asserted while the sb write is on the bus
        dm_load(14, 32'h11223344);
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 1'b0, 32'h38, 32'h000000EE);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_memwrite) seen = 1;
        end
        chk("rstwr memwrite_seen", 32'(seen), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstwr memwrite", 32'(bus.mem_memwrite), 32'h0);
        chk("rstwr mem_wdata", bus.mem_write_data, 32'h0);
        chk("rstwr stall", 32'(bus.stall), 32'h0);
        chk("rstwr mem_address", bus.mem_address, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstwr dm_word", dm[14], 32'h11223344);
        chk("rstwr stall_idle", 32'(bus.stall), 32'h0);

        // req_valid held: lw then sw, second taken only after DONE
        dm_load(4, 32'hDEADBEEF);
        dm_load(15, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        e.nm = "b2b_lw"; e.cyc = cyc + 2; e.rdata = 32'hDEADBEEF; e.err = 1'b0; sb.push_back(e);
        e.nm = "b2b_sw"; e.cyc = cyc + 5; e.rdata = 32'h0;        e.err = 1'b0; sb.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 1'b0, 32'h3C, 32'h600DF00D);
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_drain("b2b");
        @(posedge clk); #1;
        chk("b2b dm_word", dm[15], 32'h600DF00D);
        chk("b2b dm_lw_word", dm[4], 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
